// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int   UART_CLKS_PER_BIT = 434;
    localparam logic UART_IDLE_LEVEL   = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver-to-FIFO write-port and status bundle
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic             i_fifo_full;
    logic [WIDTH-1:0] o_rx_data;
    logic             o_rx_valid;
    logic             o_frame_err;
    logic             o_overrun;
    logic             o_parity_err;
    logic             o_busy;

    modport master (
        input  i_fifo_full,
        output o_rx_data, o_rx_valid, o_frame_err, o_overrun, o_parity_err, o_busy
    );

    modport slave (
        output i_fifo_full,
        input  o_rx_data, o_rx_valid, o_frame_err, o_overrun, o_parity_err, o_busy
    );
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - 2-flop synchronizer, resets to the line idle level
module uart_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= UART_IDLE_LEVEL;
            q    <= UART_IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver feeding a FIFO write port; UART_RX_PARITY_EN adds a parity bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_rx,
    uart_rx_if.master rx_if
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

    logic             rx_s;
    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;
    logic             par_bad_q, par_bad_d;

    uart_sync u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (i_rx),
        .q   (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
        case (state_q)
            IDLE: begin
                if (rx_s != UART_IDLE_LEVEL) begin
                    state_d = START;
                    cyc_d   = '0;
                end
            end
            START: begin
                // A start bit that is gone by mid-bit was a glitch
                if (cyc_q == HALF_LAST) begin
                    cyc_d = '0;
                    if (rx_s != UART_IDLE_LEVEL) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DATA: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d          = '0;
                    shift_d[bit_q] = rx_s;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d     = '0;
                    par_bad_d = rx_s ^ (^shift_q) ^ PARITY_ODD[0];
                    state_d   = STOP;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d = '0;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        state_d = IDLE;
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else if (rx_if.i_fifo_full) begin
                            ovr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                    par_bad_d = 1'b0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // Hold off through a break so it reports a single error
                if (rx_s == UART_IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_if.o_rx_data    = data_q;
    assign rx_if.o_rx_valid   = valid_q;
    assign rx_if.o_frame_err  = ferr_q;
    assign rx_if.o_overrun    = ovr_q;
    assign rx_if.o_parity_err = perr_q;
    assign rx_if.o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (CLKS_PER_BIT = 16)
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LAT   = 1 + 2 + CPB / 2 + (FRAME_BITS - 1) * CPB;
    localparam int FRAME = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_if #(.WIDTH(8)) rif ();

    uart_rx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_rx  (rx),
        .rx_if (rif)
    );

    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int unsigned n_valid = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    logic [7:0]  vdata [$];
    int unsigned vcyc  [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (rif.o_rx_valid) begin
                n_valid++;
                vdata.push_back(rif.o_rx_data);
                vcyc.push_back(cyc_cnt);
            end
            if (rif.o_frame_err)  n_ferr++;
            if (rif.o_overrun)    n_ovr++;
            if (rif.o_parity_err) n_perr++;
        end
    end

    int unsigned total = 0, passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_par);
`else
        if (bad_par) rx = 1'b1;
`endif
        drive_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int unsigned bv, bf, bo, bp, st;

    initial begin
        rif.i_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", rif.o_rx_data, 8'h00);
        check("reset_valid",   rif.o_rx_valid, 1'b0);
        check("reset_busy",    rif.o_busy, 1'b0);
        check("reset_errs",    {rif.o_frame_err, rif.o_overrun, rif.o_parity_err}, 3'b000);
        rst = 1'b0;
        idle(5);

        // single frame with latency
        bv = n_valid; bf = n_ferr; bo = n_ovr;
        st = cyc_cnt;
        send_frame(8'h61, 1'b1, 1'b0);
        idle(20);
        check("a_count", n_valid - bv, 1);
        check("a_data",  vdata[bv], 8'h61);
        check("a_lat",   vcyc[bv] - st, LAT);
        check("a_noerr", (n_ferr - bf) + (n_ovr - bo), 0);

        // back-to-back frames
        bv = n_valid;
        send_frame(8'h41, 1'b1, 1'b0);
        send_frame(8'h7A, 1'b1, 1'b0);
        idle(20);
        check("b2b_count", n_valid - bv, 2);
        check("b2b_d0",    vdata[bv], 8'h41);
        check("b2b_d1",    vdata[bv+1], 8'h7A);
        check("b2b_gap",   vcyc[bv+1] - vcyc[bv], FRAME);

        // start-bit glitch
        bv = n_valid; bf = n_ferr;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_hi", rif.o_busy, 1'b1);
        rx = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_lo", rif.o_busy, 1'b0);
        idle(10);
        check("glitch_nopulse", (n_valid - bv) + (n_ferr - bf), 0);

        // framing error followed by a break
        bv = n_valid; bf = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        idle(40);
        check("ferr_count",   n_ferr - bf, 1);
        check("ferr_novalid", n_valid - bv, 0);
        send_frame(8'h33, 1'b1, 1'b0);
        idle(20);
        check("ferr_next_count", n_valid - bv, 1);
        check("ferr_next_data",  vdata[bv], 8'h33);

        // overrun
        bv = n_valid; bo = n_ovr;
        rif.i_fifo_full = 1'b1;
        send_frame(8'h20, 1'b1, 1'b0);
        idle(20);
        rif.i_fifo_full = 1'b0;
        check("ovr_count",   n_ovr - bo, 1);
        check("ovr_novalid", n_valid - bv, 0);
        check("ovr_keep",    rif.o_rx_data, 8'h33);

        // reset mid-DATA
        bv = n_valid; bf = n_ferr; bo = n_ovr;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",    rif.o_busy, 1'b0);
        check("rst_rx_data", rif.o_rx_data, 8'h00);
        rst = 1'b0;
        idle(200);
        check("rst_nopulse", (n_valid - bv) + (n_ferr - bf) + (n_ovr - bo), 0);
        send_frame(8'h42, 1'b1, 1'b0);
        idle(20);
        check("rst_next_count", n_valid - bv, 1);
        check("rst_next_data",  vdata[bv], 8'h42);

`ifdef UART_RX_PARITY_EN
        bv = n_valid; bp = n_perr;
        send_frame(8'h61, 1'b1, 1'b1);
        idle(20);
        check("par_count",   n_perr - bp, 1);
        check("par_novalid", n_valid - bv, 0);
`else
        bp = 0;
        check("par_tied_low", n_perr + bp, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
